// File: rtl/itrx_aib_phy_jtag_pkg.sv
// Shared definitions for the AIB PHY boundary-scan segments (input, output, clock).
// Holds the shift-stage operation encoding and the counter-width helper.
package itrx_aib_phy_jtag_pkg;

  typedef enum logic [1:0] {
    BSR_HOLD    = 2'd0,
    BSR_CAPTURE = 2'd1,
    BSR_SHIFT   = 2'd2
  } bsr_op_e;

  // Number of bits needed to hold values 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Shift wins over capture; neither means the shift stage holds.
  function automatic bsr_op_e bsr_op(input logic scan_en, input logic capture_en);
    if (scan_en)         return BSR_SHIFT;
    else if (capture_en) return BSR_CAPTURE;
    else                 return BSR_HOLD;
  endfunction

endpackage

// File: rtl/itrx_aib_phy_in_bsr_if.sv
// Control, data and status bundle of one input boundary-scan segment.
// master = TAP/controller side, slave = the segment itself.
interface itrx_aib_phy_in_bsr_if
  import itrx_aib_phy_jtag_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = clog2(WIDTH + 1);

  logic             jtag_scan_en;
  logic             jtag_capture_en;
  logic             jtag_update_en;
  logic             jtag_intest;
  logic             jtag_bypass;
  logic             cmp_en;
  logic             err_clr;
  logic [WIDTH-1:0] d_i;
  logic             si;
  logic [WIDTH-1:0] d_o;
  logic             so;
  logic [CW-1:0]    shift_cnt_o;
  logic             shift_done_o;
  logic             cmp_err_o;

  modport master (
    output jtag_scan_en, jtag_capture_en, jtag_update_en, jtag_intest, jtag_bypass,
    output cmp_en, err_clr, d_i, si,
    input  d_o, so, shift_cnt_o, shift_done_o, cmp_err_o
  );

  modport slave (
    input  jtag_scan_en, jtag_capture_en, jtag_update_en, jtag_intest, jtag_bypass,
    input  cmp_en, err_clr, d_i, si,
    output d_o, so, shift_cnt_o, shift_done_o, cmp_err_o
  );

endinterface

// File: rtl/itrx_aib_phy_bsr_cnt.sv
// Saturating shift counter for a boundary-scan segment: clear on capture,
// count non-bypass shifts up to WIDTH, flag when the full segment has shifted.
module itrx_aib_phy_bsr_cnt
  import itrx_aib_phy_jtag_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          done
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != CW'(WIDTH)))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == CW'(WIDTH));

endmodule

// File: rtl/itrx_aib_phy_in_bsr.sv
// AIB JTAG input boundary-scan segment: capture/shift stage, update shadow,
// bypass bit, shift counter and sticky loopback-compare flag.
module itrx_aib_phy_in_bsr
  import itrx_aib_phy_jtag_pkg::*;
#(
  parameter int unsigned     WIDTH       = 8,
  parameter logic [WIDTH-1:0] UPD_RST_VAL = '0
) (
  input  logic                  jtag_clkdr,
  input  logic                  jtag_rstb,
  itrx_aib_phy_in_bsr_if.slave  bus
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] upd_q, upd_d;
  logic             byp_q, byp_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   shift_cat;
  logic [WIDTH-1:0] d_o_int;
  bsr_op_e          op;

  assign op        = bsr_op(bus.jtag_scan_en, bus.jtag_capture_en);
  assign d_o_int   = bus.jtag_intest ? upd_q : bus.d_i;
  // Concatenate-then-slice keeps the shift legal for WIDTH == 1.
  assign shift_cat = {bus.si, shift_q};

  always_comb begin
    shift_d = shift_q;
    byp_d   = byp_q;
    upd_d   = upd_q;
    err_d   = err_q;
    unique case (op)
      BSR_SHIFT: begin
        if (bus.jtag_bypass) byp_d   = bus.si;
        else                 shift_d = shift_cat[WIDTH:1];
      end
      BSR_CAPTURE: begin
        shift_d = d_o_int;
        if (bus.jtag_bypass) byp_d = 1'b0;
        if (bus.cmp_en)      err_d = err_q | (bus.d_i != upd_q);
      end
      default: ;
    endcase
    // Update samples the pre-edge shift stage, so a same-edge capture is not seen.
    if (bus.jtag_update_en && !bus.jtag_scan_en) upd_d = shift_q;
    if (bus.err_clr) err_d = 1'b0;
  end

  always_ff @(posedge jtag_clkdr or negedge jtag_rstb) begin
    if (!jtag_rstb) begin
      shift_q <= '0;
      upd_q   <= UPD_RST_VAL;
      byp_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      upd_q   <= upd_d;
      byp_q   <= byp_d;
      err_q   <= err_d;
    end
  end

  itrx_aib_phy_bsr_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (jtag_clkdr),
    .rst_n (jtag_rstb),
    .clr   (op == BSR_CAPTURE),
    .inc   ((op == BSR_SHIFT) && !bus.jtag_bypass),
    .cnt   (bus.shift_cnt_o),
    .done  (bus.shift_done_o)
  );

  assign bus.d_o       = d_o_int;
  assign bus.so        = bus.jtag_bypass ? byp_q : shift_q[0];
  assign bus.cmp_err_o = err_q;

endmodule

// File: tb/tb_itrx_aib_phy_in_bsr.sv
// Self-checking bench for itrx_aib_phy_in_bsr (WIDTH=8): directed scenarios
// followed by randomized traffic, all checked against a behavioural model.
module tb_itrx_aib_phy_in_bsr;

  localparam int unsigned W      = 8;
  localparam logic [7:0]  RSTVAL = 8'h5A;
  localparam int unsigned MASK   = (1 << W) - 1;

  logic clk;
  logic rstb;

  itrx_aib_phy_in_bsr_if #(.WIDTH(W)) bus ();

  itrx_aib_phy_in_bsr #(
    .WIDTH       (W),
    .UPD_RST_VAL (RSTVAL)
  ) dut (
    .jtag_clkdr (clk),
    .jtag_rstb  (rstb),
    .bus        (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  string       phase   = "init";

  // Behavioural model state
  int unsigned m_sh, m_upd, m_byp, m_cnt, m_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  function automatic int unsigned m_do();
    return bus.jtag_intest ? m_upd : int'(bus.d_i);
  endfunction

  function automatic int unsigned m_so();
    return bus.jtag_bypass ? m_byp : (m_sh & 1);
  endfunction

  task automatic model_reset();
    m_sh = 0; m_upd = RSTVAL; m_byp = 0; m_cnt = 0; m_err = 0;
  endtask

  // One rising edge of the JTAG DR clock, written from the operation rules.
  task automatic model_edge();
    int unsigned n_sh, n_upd, n_byp, n_cnt, n_err, di, si_b;
    di = int'(bus.d_i); si_b = int'(bus.si);
    n_sh = m_sh; n_upd = m_upd; n_byp = m_byp; n_cnt = m_cnt; n_err = m_err;
    if (bus.jtag_scan_en) begin
      if (bus.jtag_bypass) n_byp = si_b;
      else begin
        n_sh  = ((m_sh >> 1) | (si_b << (W - 1))) & MASK;
        n_cnt = (m_cnt < W) ? m_cnt + 1 : W;
      end
    end else if (bus.jtag_capture_en) begin
      n_sh  = m_do();
      n_cnt = 0;
      if (bus.jtag_bypass) n_byp = 0;
      if (bus.cmp_en && (di != m_upd)) n_err = 1;
    end
    if (bus.jtag_update_en && !bus.jtag_scan_en) n_upd = m_sh;
    if (bus.err_clr) n_err = 0;
    m_sh = n_sh; m_upd = n_upd; m_byp = n_byp; m_cnt = n_cnt; m_err = n_err;
  endtask

  task automatic check_all();
    check_val("so",   32'(bus.so),           32'(m_so()));
    check_val("d_o",  32'(bus.d_o),          32'(m_do()));
    check_val("cnt",  32'(bus.shift_cnt_o),  32'(m_cnt));
    check_val("done", 32'(bus.shift_done_o), 32'(m_cnt == W));
    check_val("err",  32'(bus.cmp_err_o),    32'(m_err));
  endtask

  // Inputs are set at the falling edge; the DUT samples at the next rising edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    bus.jtag_scan_en = 0; bus.jtag_capture_en = 0; bus.jtag_update_en = 0;
    bus.jtag_intest = 0;  bus.jtag_bypass = 0;     bus.cmp_en = 0;
    bus.err_clr = 0;      bus.si = 0;
  endtask

  task automatic shift_in(input logic [7:0] val);
    idle_inputs();
    for (int i = 0; i < W; i++) begin
      bus.jtag_scan_en = 1;
      bus.si = val[i];
      tick();
    end
    idle_inputs();
  endtask

  task automatic do_update();
    idle_inputs();
    bus.jtag_update_en = 1;
    tick();
    idle_inputs();
  endtask

  logic [7:0] seq;

  initial begin
    idle_inputs();
    bus.d_i = '0;
    rstb = 1'b0;
    model_reset();
    @(negedge clk);
    phase = "reset";
    check_all();
    check_val("so_const", 32'(bus.so), 32'd0);
    rstb = 1'b1;

    // Capture 0x3C then shift it out LSB first
    phase = "capshift";
    bus.d_i = 8'h3C;
    bus.jtag_capture_en = 1;
    tick();
    idle_inputs();
    seq = '0;
    seq[0] = bus.so;
    for (int i = 1; i < W; i++) begin
      bus.jtag_scan_en = 1;
      tick();
      seq[i] = bus.so;
    end
    check_val("so_seq", 32'(seq), 32'h3C);
    check_val("done_pre", 32'(bus.shift_done_o), 32'd0);
    tick();
    check_val("done_8", 32'(bus.shift_done_o), 32'd1);
    tick();
    check_val("cnt_sat", 32'(bus.shift_cnt_o), 32'd8);
    idle_inputs();

    // Shift/update/intest
    phase = "update";
    shift_in(8'h96);
    do_update();
    bus.jtag_intest = 1;
    #1 check_val("d_o_96", 32'(bus.d_o), 32'h96);
    for (int i = 0; i < 4; i++) begin
      bus.jtag_scan_en = 1; bus.si = 1'(i);
      tick();
    end
    check_val("d_o_hold", 32'(bus.d_o), 32'h96);
    bus.jtag_update_en = 1;
    tick();
    check_val("upd_ignored", 32'(bus.d_o), 32'h96);
    idle_inputs();

    // Bypass: one-edge path, counter and shift stage untouched
    phase = "bypass";
    shift_in(8'hC3);
    bus.jtag_bypass = 1;
    for (int i = 0; i < 3; i++) begin
      bus.jtag_scan_en = 1;
      bus.si = (i != 1);
      tick();
      check_val("byp_so", 32'(bus.so), 32'(i != 1));
    end
    check_val("byp_cnt", 32'(bus.shift_cnt_o), 32'd8);
    idle_inputs();
    #1 check_val("byp_keep", 32'(bus.so), 32'd1);

    // Compare
    phase = "compare";
    shift_in(8'h55);
    do_update();
    bus.d_i = 8'h54; bus.jtag_capture_en = 1; bus.cmp_en = 1;
    tick();
    check_val("err_set", 32'(bus.cmp_err_o), 32'd1);
    bus.d_i = 8'h55;
    tick();
    check_val("err_sticky", 32'(bus.cmp_err_o), 32'd1);
    bus.d_i = 8'h00; bus.err_clr = 1;
    tick();
    check_val("err_clr", 32'(bus.cmp_err_o), 32'd0);
    idle_inputs();

    // Simultaneous capture + update
    phase = "capupd";
    shift_in(8'h0F);
    bus.d_i = 8'hF0; bus.jtag_capture_en = 1; bus.jtag_update_en = 1;
    tick();
    idle_inputs();
    bus.jtag_intest = 1;
    #1 check_val("upd_old", 32'(bus.d_o), 32'h0F);
    seq = '0;
    for (int i = 0; i < W; i++) begin
      seq[i] = bus.so;
      bus.jtag_scan_en = 1;
      tick();
    end
    check_val("shift_new", 32'(seq), 32'hF0);
    idle_inputs();

    // Reset in the middle of a shift, with the error flag set
    phase = "rst_mid";
    bus.d_i = 8'hFF; bus.jtag_capture_en = 1; bus.cmp_en = 1;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.jtag_scan_en = 1; bus.si = (8'hA5 >> i) & 1;
      tick();
    end
    bus.jtag_intest = 1;
    #2 rstb = 1'b0;
    model_reset();
    #1;
    check_val("so0",  32'(bus.so),          32'd0);
    check_val("cnt0", 32'(bus.shift_cnt_o), 32'd0);
    check_val("err0", 32'(bus.cmp_err_o),   32'd0);
    check_val("d_o_rst", 32'(bus.d_o),      32'(RSTVAL));
    @(negedge clk);
    rstb = 1'b1;
    idle_inputs();

    // Randomized traffic, with occasional asynchronous resets
    phase = "random";
    for (int n = 0; n < 600; n++) begin
      bus.jtag_scan_en    = ($urandom_range(0, 99) < 45);
      bus.jtag_capture_en = ($urandom_range(0, 99) < 25);
      bus.jtag_update_en  = ($urandom_range(0, 99) < 25);
      bus.jtag_intest     = 1'($urandom);
      bus.jtag_bypass     = ($urandom_range(0, 99) < 20);
      bus.cmp_en          = 1'($urandom);
      bus.err_clr         = ($urandom_range(0, 99) < 5);
      bus.si              = 1'($urandom);
      bus.d_i             = ($urandom_range(0, 3) == 0) ? 8'(m_upd) : 8'($urandom);
      if ($urandom_range(0, 99) < 2) begin
        #2 rstb = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rstb = 1'b1;
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/itrx_aib_phy_in_bsr.md
# itrx_aib_phy_in_bsr

Parametrised AIB JTAG input boundary-scan register segment: WIDTH input cells with capture, serial shift, a separate update (shadow) stage, a per-segment bypass bit, a shift counter and a sticky loopback-compare flag. It sits between the AIB receive pads (`d_i`) and core logic (`d_o`) and links into the PHY boundary-scan chain through `si`/`so`. The update stage keeps INTEST data stable while the chain shifts.

## Interface
- `WIDTH`, 8: number of input cells, 1..256.
- `UPD_RST_VAL`, {WIDTH{1'b0}}: reset value of the update stage.
- `jtag_clkdr` in 1: JTAG data-register clock; all flops on its rising edge.
- `jtag_rstb` in 1: reset, asynchronous, active-low.
- `jtag_scan_en` in 1: shift enable.
- `jtag_capture_en` in 1: parallel capture into the shift stage.
- `jtag_update_en` in 1: transfer from the shift stage to the update stage.
- `jtag_intest` in 1: 1 drives `d_o` from the update stage.
- `jtag_bypass` in 1: 1 routes `si` through the single bypass flop.
- `cmp_en` in 1: enables the compare on capture.
- `err_clr` in 1: clears the sticky compare error.
- `d_i` in WIDTH: pad-side data.
- `si` in 1: scan in.
- `d_o` out WIDTH: core-side data.
- `so` out 1: scan out.
- `shift_cnt_o` out $clog2(WIDTH+1): shifts since the last capture, saturating.
- `shift_done_o` out 1: `shift_cnt_o == WIDTH`.
- `cmp_err_o` out 1: sticky loopback-compare mismatch.

## Operation
- Registers: `shift_q`[WIDTH], `upd_q`[WIDTH], `byp_q`, `cnt_q`, `err_q`.
- `d_o = jtag_intest ? upd_q : d_i` (combinational).
- `so = jtag_bypass ? byp_q : shift_q[0]` (combinational mux of flop outputs).
- **Shift-stage priority per edge:** scan_en > capture_en > hold.
  - **Shift** (`jtag_bypass`=0): `shift_q <= {si, shift_q[WIDTH-1:1]}`.
  - **Shift** (`jtag_bypass`=1): `byp_q <= si`; `shift_q` holds.
  - **Capture:** `shift_q <= d_o`. With `jtag_intest`=0 this is the pad value; with `jtag_intest`=1 it is a loopback of `upd_q`.
  - When `jtag_bypass`=1, capture also loads `byp_q <= 0`.
- **Update:** `upd_q <= shift_q` only when `jtag_update_en`=1 and `jtag_scan_en`=0. Update with scan_en=1 is ignored.
  - Update together with capture: `upd_q` takes the old `shift_q` (pre-capture value).
- **Counter:**
  - Capture clears `cnt_q` to 0.
  - Each shift with bypass=0 increments `cnt_q`, saturating at WIDTH.
  - Shifts in bypass leave `cnt_q` unchanged.
- **Compare:** on a capture edge with `cmp_en`=1, `err_q <= err_q | (d_i != upd_q)`.
  - `err_clr` forces `err_q <= 0` and wins over a simultaneous mismatch.
  - Compare uses the raw `d_i` regardless of `jtag_intest`.
- **Reset** (`jtag_rstb`=0, any time, including mid-shift):
  - `shift_q`=0, `byp_q`=0, `cnt_q`=0, `err_q`=0, `upd_q`=UPD_RST_VAL.
  - Hence `so`=0 and `shift_done_o`=0.
  - `d_o` = `d_i`, or UPD_RST_VAL when `jtag_intest`=1.
  - Release is asynchronous; the first active edge after deassertion operates normally.

## Timing
- Single clock domain `jtag_clkdr`; `d_i` is sampled at the edge and must be stable around it.
- `si` to `so` latency:
  - WIDTH edges through the chain: bit pushed at edge k appears on `so` after edge k+WIDTH-1.
  - 1 edge in bypass.
- Capture to first captured bit on `so`: `d_i[0]` visible right after the capture edge.
- Update to `d_o` (intest=1): valid after the update edge, combinational thereafter.
- `shift_done_o` asserts after the WIDTH-th shift edge following a capture and stays high until the next capture or reset.

## Structure
- Shared package `itrx_aib_phy_jtag_pkg`:
  - operation priority encoding constants (SHIFT/CAPTURE/HOLD);
  - the counter-width function `clog2`.
  - These constants are reused by the output and clock BSR segments.
- One sub-module `itrx_aib_phy_bsr_cnt`: saturating shift counter with clear, parameterised on WIDTH, exposing count and done.
- The rest is flat.

## Test plan
- Reset mid-shift: assert `jtag_rstb`=0 after 3 shifts of 0xA5 pattern -> `so`=0, `shift_cnt_o`=0, `cmp_err_o`=0; with intest=1 `d_o`=UPD_RST_VAL.
- Capture/shift, WIDTH=8, `d_i`=0x3C: capture, then 8 shifts -> `so` sequence 0,0,1,1,1,1,0,0 (LSB first); `shift_done_o` rises after the 8th edge; `shift_cnt_o` holds 8 on a 9th shift.
- Shift/update/intest:
  - Shift in 0x96, then update with scan_en=0 -> intest=1 gives `d_o`=0x96.
  - A further 4 shifts leave `d_o`=0x96.
  - Update with scan_en=1 is ignored.
- Bypass: bypass=1, drive `si`=1,0,1 -> `so`=1,0,1 one edge later; `shift_cnt_o` unchanged; `shift_q` contents preserved.
- Compare:
  - `upd_q`=0x55, `d_i`=0x54, capture with cmp_en=1 -> `cmp_err_o`=1.
  - Stays set after a matching capture.
  - `err_clr` together with a mismatch capture -> 0.
- Simultaneous capture+update: `shift_q`=0x0F, `d_i`=0xF0 -> `upd_q`=0x0F, `shift_q`=0xF0.
